dividend_rebuild_seq: RTL and testbench

DIVIDEND_REBUILD_SEQ -- requirements
Module: dividend_rebuild_seq

---
 rtl/dividend_rebuild_seq_pkg.sv | 19 +
 rtl/dividend_rebuild_seq_rebuild_step.sv | 22 ++
 rtl/dividend_rebuild_seq.sv | 139 +++++++++++++
 tb/tb_dividend_rebuild_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dividend_rebuild_seq_pkg.sv
// Shared widths, FSM state type and iteration count for the dividend
// reconstruction block.
package dividend_rebuild_seq_pkg;

  localparam int unsigned Q_W   = 8;
  localparam int unsigned D_W   = 8;
  localparam int unsigned N_W   = 16;
  localparam int unsigned SUM_W = 24;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned ITER  = 8;
  localparam int unsigned BIT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dividend_rebuild_seq_rebuild_step.sv
// One shift-add step of the quotient*divisor rebuild: adds d << bit_idx to
// the accumulator when the selected quotient bit is set.
module rebuild_step
  import dividend_rebuild_seq_pkg::*;
(
  input  logic [N_W-1:0]   acc_i,
  input  logic [D_W-1:0]   d_i,
  input  logic [BIT_W-1:0] bit_idx,
  input  logic             q_bit,
  output logic [N_W-1:0]   acc_o
);

  logic [N_W-1:0] d_ext;
  logic [N_W-1:0] d_shift;

  always_comb begin
    d_ext   = {{(N_W-D_W){1'b0}}, d_i};
    d_shift = d_ext << bit_idx;
    acc_o   = q_bit ? (acc_i + d_shift) : acc_i;
  end

endmodule

// File: rtl/dividend_rebuild_seq.sv
// Rebuilds a dividend as q*d + r over eight shift-add cycles, reports the
// error against the reference dividend and keeps saturating statistics.
module dividend_rebuild_seq
  import dividend_rebuild_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Q_W-1:0]   q,
  input  logic [D_W-1:0]   d,
  input  logic [7:0]       r,
  input  logic [N_W-1:0]   n_ref,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_W-1:0]   n_out,
  output logic [N_W-1:0]   err,
  output logic             mismatch,
  output logic [SUM_W-1:0] err_sum,
  output logic [CNT_W-1:0] sample_cnt,
  input  logic             clr
);

  state_e           state_q, state_d;
  logic [Q_W-1:0]   q_lat_q, q_lat_d;
  logic [D_W-1:0]   d_lat_q, d_lat_d;
  logic [N_W-1:0]   n_ref_q, n_ref_d;
  logic [N_W-1:0]   acc_q, acc_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [N_W-1:0]   n_out_q, n_out_d;
  logic [N_W-1:0]   err_q, err_d;
  logic             mismatch_q, mismatch_d;
  logic [SUM_W-1:0] err_sum_q, err_sum_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;

  logic [N_W-1:0]   acc_step;
  logic [SUM_W:0]   sum_ext;
  logic             handshake;

  rebuild_step u_step (
    .acc_i   (acc_q),
    .d_i     (d_lat_q),
    .bit_idx (bit_q),
    .q_bit   (q_lat_q[bit_q]),
    .acc_o   (acc_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      q_lat_q      <= '0;
      d_lat_q      <= '0;
      n_ref_q      <= '0;
      acc_q        <= '0;
      bit_q        <= '0;
      n_out_q      <= '0;
      err_q        <= '0;
      mismatch_q   <= 1'b0;
      err_sum_q    <= '0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      q_lat_q      <= q_lat_d;
      d_lat_q      <= d_lat_d;
      n_ref_q      <= n_ref_d;
      acc_q        <= acc_d;
      bit_q        <= bit_d;
      n_out_q      <= n_out_d;
      err_q        <= err_d;
      mismatch_q   <= mismatch_d;
      err_sum_q    <= err_sum_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    q_lat_d      = q_lat_q;
    d_lat_d      = d_lat_q;
    n_ref_d      = n_ref_q;
    acc_d        = acc_q;
    bit_d        = bit_q;
    n_out_d      = n_out_q;
    err_d        = err_q;
    mismatch_d   = mismatch_q;
    err_sum_d    = err_sum_q;
    sample_cnt_d = sample_cnt_q;
    handshake    = (state_q == DONE) && out_ready;
    sum_ext      = {1'b0, err_sum_q} + {{(SUM_W+1-N_W){1'b0}}, err_q};

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          q_lat_d = q;
          d_lat_d = d;
          n_ref_d = n_ref;
          acc_d   = {8'h00, r};
          bit_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_step;
        bit_d = bit_q + 1'b1;
        // Results are captured from the final step's sum so DONE starts with them.
        if (bit_q == BIT_W'(ITER - 1)) begin
          state_d    = DONE;
          n_out_d    = acc_step;
          err_d      = (n_ref_q >= acc_step) ? (n_ref_q - acc_step)
                                             : (acc_step - n_ref_q);
          mismatch_d = (n_ref_q != acc_step);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      err_sum_d    = '0;
      sample_cnt_d = '0;
    end else if (handshake) begin
      err_sum_d    = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      sample_cnt_d = (sample_cnt_q == '1) ? sample_cnt_q : sample_cnt_q + 1'b1;
    end
  end

  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == DONE);
    n_out      = n_out_q;
    err        = err_q;
    mismatch   = mismatch_q;
    err_sum    = err_sum_q;
    sample_cnt = sample_cnt_q;
  end

endmodule

// File: tb/tb_dividend_rebuild_seq.sv
// Self-checking bench: a transaction-level model tracks expected outputs every
// cycle, and directed scenarios pin literal values.
module tb_dividend_rebuild_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, clr;
  logic        in_ready, out_valid, mismatch;
  logic [7:0]  q, d, r;
  logic [15:0] n_ref, n_out, err, sample_cnt;
  logic [23:0] err_sum;

  int checks = 0;
  int failures = 0;

  dividend_rebuild_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .q(q), .d(d), .r(r), .n_ref(n_ref), .out_valid(out_valid),
    .out_ready(out_ready), .n_out(n_out), .err(err), .mismatch(mismatch),
    .err_sum(err_sum), .sample_cnt(sample_cnt), .clr(clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Transaction model: phase 0 waiting, 1 computing, 2 holding a result.
  int m_phase = 0, m_left = 0, m_live = 0;
  int m_n = 0, m_err = 0, m_sum = 0, m_cnt = 0;
  int pend_n = 0, pend_e = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_left = 0; m_n = 0; m_err = 0; m_sum = 0; m_cnt = 0;
      m_live = 1;
    end else begin
      if (clr) begin
        m_sum = 0; m_cnt = 0;
      end else if (m_phase == 2 && out_ready) begin
        m_sum = (m_sum + m_err > 'hFFFFFF) ? 'hFFFFFF : m_sum + m_err;
        m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
      end
      case (m_phase)
        0: if (in_valid) begin
          pend_n = int'(q) * int'(d) + int'(r);
          pend_e = (int'(n_ref) > pend_n) ? int'(n_ref) - pend_n : pend_n - int'(n_ref);
          m_left = 8;
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_phase = 2; m_n = pend_n; m_err = pend_e;
          end
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_live != 0) begin
      chk("in_ready", in_ready, m_phase == 0);
      chk("out_valid", out_valid, m_phase == 2);
      chk("n_out", n_out, m_n);
      chk("err", err, m_err);
      chk("mismatch", mismatch, m_err != 0);
      chk("err_sum", err_sum, m_sum);
      chk("sample_cnt", sample_cnt, m_cnt);
    end
  end

  task automatic accept(input logic [7:0] qi, di, ri, input logic [15:0] ni);
    int k = 0;
    @(negedge clk);
    in_valid = 1'b1; q = qi; d = di; r = ri; n_ref = ni;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("accept_timeout", k, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'($urandom_range(0, 1));
    q = 8'($urandom); d = 8'($urandom); r = 8'($urandom); n_ref = 16'($urandom);
  endtask

  task automatic finish(input int stall, input logic clr_hs, output int lat);
    logic [15:0] hold_n;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_valid = out_valid ? 1'b0 : 1'($urandom_range(0, 1));
      q = 8'($urandom); d = 8'($urandom); r = 8'($urandom); n_ref = 16'($urandom);
    end
    in_valid = 1'b0;
    hold_n = n_out;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_n_out", n_out, hold_n);
    end
    out_ready = 1'b1;
    clr = clr_hs;
    @(negedge clk);
    out_ready = 1'b0;
    clr = 1'b0;
  endtask

  task automatic run(input logic [7:0] qi, di, ri, input logic [15:0] ni, output int lat);
    accept(qi, di, ri, ni);
    finish(0, 1'b0, lat);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
    q = '0; d = '0; r = '0; n_ref = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_n_out", n_out, 0);
    chk("rst_err_sum", err_sum, 0);
    chk("rst_sample_cnt", sample_cnt, 0);

    run(8'h0A, 8'h07, 8'h03, 16'd73, lat);
    chk("t1_latency", lat, 8);
    chk("t1_n_out", n_out, 73);
    chk("t1_err", err, 0);
    chk("t1_mismatch", mismatch, 0);
    chk("t1_in_ready_after", in_ready, 1);

    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("clr_err_sum", err_sum, 0);
    chk("clr_sample_cnt", sample_cnt, 0);

    run(8'hFF, 8'hFF, 8'hFF, 16'd65280, lat);
    chk("t2_n_out", n_out, 65280);
    chk("t2_err", err, 0);
    run(8'h0A, 8'h07, 8'h03, 16'd100, lat);
    chk("t2b_err", err, 27);
    chk("t2b_mismatch", mismatch, 1);
    chk("t2b_err_sum", err_sum, 27);
    chk("t2b_sample_cnt", sample_cnt, 2);

    run(8'hFF, 8'h00, 8'h05, 16'd5, lat);
    chk("t3_latency", lat, 8);
    chk("t3_n_out", n_out, 5);

    accept(8'h03, 8'h10, 8'h01, 16'd60);
    finish(5, 1'b0, lat);
    chk("t4_n_out", n_out, 49);
    chk("t4_err", err, 11);
    chk("t4_in_ready_after_hs", in_ready, 1);

    accept(8'hFF, 8'hFF, 8'h00, 16'd0);
    repeat (4) @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_in_ready", in_ready, 1);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_err_sum", err_sum, 0);
    chk("t5_sample_cnt", sample_cnt, 0);
    run(8'h12, 8'h34, 8'h56, 16'd1022, lat);
    chk("t5_n_out", n_out, 1022);
    chk("t5_mismatch", mismatch, 0);

    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    for (int i = 0; i < 256; i++) run(8'h00, 8'h00, 8'h00, 16'hFFFF, lat);
    run(8'h00, 8'h00, 8'h00, 16'd240, lat);
    chk("t6_preload_sum", err_sum, 24'hFFFFF0);
    chk("t6_preload_cnt", sample_cnt, 257);
    run(8'h00, 8'h00, 8'h00, 16'h0100, lat);
    chk("t6_err", err, 256);
    chk("t6_saturated_sum", err_sum, 24'hFFFFFF);
    accept(8'h01, 8'h01, 8'h00, 16'd9);
    finish(0, 1'b1, lat);
    chk("t6_clr_sum", err_sum, 0);
    chk("t6_clr_cnt", sample_cnt, 0);
    chk("t6_err_kept", err, 8);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
